// File: rtl/pipe_stage_reg.sv
// Generic flow-controlled pipeline stage with a control and a data bundle; an accepted entry is visible right after its accept edge.
// Backpressure: SKID=1 accepts one extra entry into a skid register behind a registered in_ready; SKID=0 passes out_ready combinationally to in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              vld;
    logic              rdy;
    logic [1:0]        occ;
    logic              in_fire;
    logic              out_fire;
    logic [CNT_W-1:0]  stall_q;

    assign in_fire  = in_valid & rdy;
    assign out_fire = vld & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t            state;
            logic              rdy_q;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // rdy_q always tracks (next state != ST_FULL), so in_ready never sees out_ready.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state     <= ST_EMPTY;
                    rdy_q     <= 1'b1;
                    main_ctrl <= '0;
                    main_data <= '0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else if (flush) begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                main_ctrl <= in_ctrl;
                                main_data <= in_data;
                                state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_ctrl <= in_ctrl;
                                main_data <= in_data;
                            end else if (out_fire) begin
                                state <= ST_EMPTY;
                            end else if (in_fire) begin
                                skid_ctrl <= in_ctrl;
                                skid_data <= in_data;
                                state     <= ST_FULL;
                                rdy_q     <= 1'b0;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire) begin
                                main_ctrl <= skid_ctrl;
                                main_data <= skid_data;
                                state     <= ST_ONE;
                                rdy_q     <= 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_EMPTY;
                            rdy_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign vld = (state != ST_EMPTY);
            assign rdy = rdy_q;
            assign occ = (state == ST_FULL) ? 2'd2 :
                         (state == ST_ONE)  ? 2'd1 : 2'd0;
        end else begin : g_flop
            logic vld_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q     <= 1'b0;
                    main_ctrl <= '0;
                    main_data <= '0;
                end else if (flush) begin
                    vld_q <= 1'b0;
                end else if (in_fire) begin
                    vld_q     <= 1'b1;
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else if (out_fire) begin
                    vld_q <= 1'b0;
                end
            end

            assign vld = vld_q;
            assign rdy = !vld_q | out_ready;
            assign occ = {1'b0, vld_q};
        end
    endgenerate

    // Stall counter survives flushes; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (vld && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

    assign in_ready  = rdy;
    assign out_valid = vld;
    assign out_ctrl  = main_ctrl & {CTRL_W{vld}};
    assign out_data  = main_data;
    assign occupancy = occ;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg in both skid modes, driven with shared stimulus.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 101;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occ;
    logic [3:0]        s_stall;

    logic              f_in_ready, f_out_valid;
    logic [CTRL_W-1:0] f_out_ctrl;
    logic [DATA_W-1:0] f_out_data;
    logic [1:0]        f_occ;
    logic [15:0]       f_stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [CTRL_W+DATA_W-1:0] q_s[$];
    logic [CTRL_W+DATA_W-1:0] q_f[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) u_flop (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_ctrl(f_out_ctrl), .out_data(f_out_data),
        .occupancy(f_occ), .stall_cnt(f_stall)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference queues: every accepted entry must come out once, in order, until a flush or reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_s.delete();
            q_f.delete();
        end else begin
            check_eq("s_occ", 128'(s_occ), 128'(q_s.size()));
            check_eq("s_vld", 128'(s_out_valid), 128'(q_s.size() != 0));
            check_eq("s_rdy", 128'(s_in_ready), 128'(q_s.size() < 2));
            if (!s_out_valid) check_eq("s_gate", 128'(s_out_ctrl), 128'(0));
            if (s_out_valid && out_ready && q_s.size() != 0) begin
                check_eq("s_order", 128'({s_out_ctrl, s_out_data}), 128'(q_s[0]));
                void'(q_s.pop_front());
            end
            if (flush) q_s.delete();
            else if (in_valid && s_in_ready) q_s.push_back({in_ctrl, in_data});

            check_eq("f_occ", 128'(f_occ), 128'(q_f.size()));
            check_eq("f_vld", 128'(f_out_valid), 128'(q_f.size() != 0));
            check_eq("f_rdy", 128'(f_in_ready), 128'((q_f.size() == 0) || out_ready));
            if (!f_out_valid) check_eq("f_gate", 128'(f_out_ctrl), 128'(0));
            if (f_out_valid && out_ready && q_f.size() != 0) begin
                check_eq("f_order", 128'({f_out_ctrl, f_out_data}), 128'(q_f[0]));
                void'(q_f.pop_front());
            end
            if (flush) q_f.delete();
            else if (in_valid && f_in_ready) q_f.push_back({in_ctrl, in_data});
        end
    end

    initial begin
        logic [127:0] rnd;

        // Reset with a live-looking input present.
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 4'hF;
        in_data = DATA_W'(1); out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_s_vld",   128'(s_out_valid), 128'(0));
        check_eq("rst_s_ctrl",  128'(s_out_ctrl),  128'(0));
        check_eq("rst_s_data",  128'(s_out_data),  128'(0));
        check_eq("rst_s_occ",   128'(s_occ),       128'(0));
        check_eq("rst_s_stall", 128'(s_stall),     128'(0));
        check_eq("rst_f_vld",   128'(f_out_valid), 128'(0));
        check_eq("rst_f_ctrl",  128'(f_out_ctrl),  128'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        check_eq("rst_s_rdy", 128'(s_in_ready), 128'(1));
        check_eq("rst_f_rdy", 128'(f_in_ready), 128'(1));

        // Streaming: each entry visible one edge after it is offered.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i);
            tick();
            check_eq("strm_s_data", 128'(s_out_data),  128'(i));
            check_eq("strm_s_ctrl", 128'(s_out_ctrl),  128'(i));
            check_eq("strm_s_vld",  128'(s_out_valid), 128'(1));
            check_eq("strm_s_occ",  128'(s_occ),       128'(1));
            check_eq("strm_f_data", 128'(f_out_data),  128'(i));
            check_eq("strm_f_occ",  128'(f_occ),       128'(1));
        end
        in_valid = 1'b0;
        tick();
        check_eq("strm_s_drain", 128'(s_out_valid), 128'(0));
        check_eq("strm_f_drain", 128'(f_out_valid), 128'(0));

        // Backpressure: 0xB lands in skid, then in_ready drops.
        in_valid = 1'b1; in_data = DATA_W'('hA); in_ctrl = 4'h1;
        tick();
        check_eq("bp_a_out", 128'(s_out_data), 128'('hA));
        out_ready = 1'b0; in_data = DATA_W'('hB); in_ctrl = 4'h2;
        check_eq("bp_rdy_before", 128'(s_in_ready), 128'(1));
        tick();
        in_data = DATA_W'('hC); in_ctrl = 4'h3;
        check_eq("bp_occ_full", 128'(s_occ),      128'(2));
        check_eq("bp_rdy_full", 128'(s_in_ready), 128'(0));
        check_eq("bp_hold_a",   128'(s_out_data), 128'('hA));
        tick();
        tick();
        check_eq("bp_stall", 128'(s_stall), 128'(3));
        check_eq("bp_occ2",  128'(s_occ),   128'(2));
        out_ready = 1'b1;
        tick();
        check_eq("bp_b_out", 128'(s_out_data), 128'('hB));
        check_eq("bp_occ1",  128'(s_occ),      128'(1));
        check_eq("bp_rdy_back", 128'(s_in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        check_eq("bp_c_out", 128'(s_out_data),  128'('hC));
        check_eq("bp_c_vld", 128'(s_out_valid), 128'(1));
        tick();
        check_eq("bp_empty", 128'(s_out_valid), 128'(0));
        check_eq("bp_stall_hold", 128'(s_stall), 128'(3));

        // Flush while FULL: 0xD offered in the flush cycle is dropped.
        in_valid = 1'b1; in_data = DATA_W'('h11); in_ctrl = 4'h4; out_ready = 1'b0;
        tick();
        in_data = DATA_W'('h12); in_ctrl = 4'h5;
        tick();
        check_eq("fl_occ_full", 128'(s_occ), 128'(2));
        flush = 1'b1; in_data = DATA_W'('hD); in_ctrl = 4'hD;
        tick();
        check_eq("fl_vld",   128'(s_out_valid), 128'(0));
        check_eq("fl_ctrl",  128'(s_out_ctrl),  128'(0));
        check_eq("fl_occ",   128'(s_occ),       128'(0));
        check_eq("fl_rdy",   128'(s_in_ready),  128'(1));
        check_eq("fl_stall", 128'(s_stall),     128'(5));
        check_eq("fl_f_vld", 128'(f_out_valid), 128'(0));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_eq("fl_no_d", 128'(s_out_valid), 128'(0));

        // Saturation of the 4-bit stall counter.
        in_valid = 1'b1; in_data = DATA_W'('h21); in_ctrl = 4'h6; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check_eq("sat_15", 128'(s_stall), 128'(15));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("sat_flush_keep", 128'(s_stall), 128'(15));
        check_eq("sat_flush_occ",  128'(s_occ),   128'(0));

        // Reset while FULL discards both entries and clears the counter.
        in_valid = 1'b1; in_data = DATA_W'('h31); in_ctrl = 4'h7;
        tick();
        in_data = DATA_W'('h32); in_ctrl = 4'h8;
        tick();
        check_eq("mrst_full", 128'(s_occ), 128'(2));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        check_eq("mrst_occ",   128'(s_occ),       128'(0));
        check_eq("mrst_vld",   128'(s_out_valid), 128'(0));
        check_eq("mrst_stall", 128'(s_stall),     128'(0));
        check_eq("mrst_rdy",   128'(s_in_ready),  128'(1));

        // Random soak; the negedge scoreboard does the checking.
        for (int c = 0; c < 10000; c++) begin
            rnd       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_ctrl   = CTRL_W'($urandom_range(0, 15));
            in_data   = rnd[DATA_W-1:0];
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("soak_s_drained", 128'(s_out_valid), 128'(0));
        check_eq("soak_f_drained", 128'(f_out_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
